// File: rtl/gs_filter_pkg.sv
// rtl/gs_filter_pkg.sv - shared types and constants for the Gaussian line filter
package gs_filter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } gs_state_e;

  localparam logic MODE_5TAP   = 1'b0;
  localparam logic MODE_3TAP   = 1'b1;
  localparam logic BORDER_ZERO = 1'b0;
  localparam logic BORDER_REPL = 1'b1;

  // Tap weights: 5-tap [1,4,6,4,1], 3-tap [1,2,1]
  localparam int unsigned TAP5_OUTER  = 1;
  localparam int unsigned TAP5_INNER  = 4;
  localparam int unsigned TAP5_CENTRE = 6;
  localparam int unsigned TAP3_OUTER  = 1;
  localparam int unsigned TAP3_CENTRE = 2;

  // Round-half-up constants and normalising shifts (gain 16 and 4)
  localparam int unsigned RND_5TAP   = 8;
  localparam int unsigned RND_3TAP   = 2;
  localparam int unsigned SHIFT_5TAP = 4;
  localparam int unsigned SHIFT_3TAP = 2;

  // Synthetic shifts needed after the last sample to centre the trailing outputs
  localparam logic [1:0] FLUSH_5TAP = 2'd2;
  localparam logic [1:0] FLUSH_3TAP = 2'd1;

  function automatic logic [1:0] flush_count(input logic mode);
    return (mode == MODE_3TAP) ? FLUSH_3TAP : FLUSH_5TAP;
  endfunction

endpackage

// File: rtl/gs_filter_pipe.sv
// rtl/gs_filter_pipe.sv - window-to-output arithmetic: two adder stages plus round register
module gs_filter_pipe
  import gs_filter_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          mode_i,
  input  logic [DW-1:0] w0_i,
  input  logic [DW-1:0] w1_i,
  input  logic [DW-1:0] w2_i,
  input  logic [DW-1:0] w3_i,
  input  logic [DW-1:0] w4_i,
  input  logic          vld_i,
  input  logic          last_i,
  output logic          vld_o,
  output logic          last_o,
  output logic [DW-1:0] data_o
);

  // Four extra bits hold the full gain-16 sum of the 5-tap kernel plus rounding
  localparam int SW = DW + 4;

  logic [SW-1:0] outer_d, inner_d, centre_d;
  logic [SW-1:0] outer_q, inner_q, centre_q;
  logic          s1_vld_q, s1_last_q;
  logic [SW-1:0] sum_d, sum_q;
  logic          s2_vld_q, s2_last_q;
  logic [SW-1:0] rounded;
  logic [DW-1:0] data_d, data_q;
  logic          vld_q, last_q;

  // Stage 1: weighted partial products, grouped by symmetric tap pairs
  always_comb begin
    outer_d  = '0;
    inner_d  = '0;
    centre_d = '0;
    if (mode_i == MODE_3TAP) begin
      outer_d  = SW'(TAP3_OUTER) * (SW'(w0_i) + SW'(w2_i));
      centre_d = SW'(TAP3_CENTRE) * SW'(w1_i);
    end else begin
      outer_d  = SW'(TAP5_OUTER) * (SW'(w0_i) + SW'(w4_i));
      inner_d  = SW'(TAP5_INNER) * (SW'(w1_i) + SW'(w3_i));
      centre_d = SW'(TAP5_CENTRE) * SW'(w2_i);
    end
  end

  // Stage 2 and round: total sum, then add half an LSB and normalise
  always_comb begin
    sum_d   = outer_q + inner_q + centre_q;
    rounded = '0;
    data_d  = data_q;
    if (mode_i == MODE_3TAP) begin
      rounded = sum_q + SW'(RND_3TAP);
      data_d  = DW'(rounded >> SHIFT_3TAP);
    end else begin
      rounded = sum_q + SW'(RND_5TAP);
      data_d  = DW'(rounded >> SHIFT_5TAP);
    end
  end

  // Data registers: free-running, output data only updates on a valid result
  always_ff @(posedge clk) begin
    if (rst) begin
      outer_q  <= '0;
      inner_q  <= '0;
      centre_q <= '0;
      sum_q    <= '0;
      data_q   <= '0;
    end else begin
      outer_q  <= outer_d;
      inner_q  <= inner_d;
      centre_q <= centre_d;
      sum_q    <= sum_d;
      if (s2_vld_q) begin
        data_q <= data_d;
      end
    end
  end

  // Valid/last tags travel alongside the data; a new line start kills in-flight results
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_last_q <= 1'b0;
      vld_q     <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      s1_vld_q  <= vld_i;
      s1_last_q <= vld_i & last_i;
      s2_vld_q  <= s1_vld_q;
      s2_last_q <= s1_last_q;
      vld_q     <= s2_vld_q;
      last_q    <= s2_last_q;
    end
  end

  assign vld_o  = vld_q;
  assign last_o = last_q;
  assign data_o = data_q;

endmodule

// File: rtl/gs_filter_line.sv
// rtl/gs_filter_line.sv - 1-D Gaussian line filter fed from ping-pong line RAMs
module gs_filter_line
  import gs_filter_pkg::*;
#(
  parameter int DW       = 8,
  parameter int LINE_LEN = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic          border,
  input  logic          ram0_valid_in,
  input  logic [DW-1:0] ram0_data_in,
  input  logic          ram1_valid_in,
  input  logic [DW-1:0] ram1_data_in,
  output logic          op_valid_out,
  output logic [DW-1:0] op_data_out,
  output logic          line_done,
  output logic [1:0]    err_flags
);

  localparam int CW = $clog2(LINE_LEN + 1);

  gs_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    fl_q, fl_d;
  logic          mode_q, mode_d;
  logic          border_q, border_d;
  logic [1:0]    err_q, err_d;
  logic [DW-1:0] w_q [5];
  logic [DW-1:0] w_d [5];
  logic          win_vld_q, win_vld_d;
  logic          win_last_q, win_last_d;

  logic          one_valid, both_valid, accept, flush_shift;
  logic [DW-1:0] x;
  logic [DW-1:0] pad_first, pad_flush;

  // Input mux and qualification; start wins over any same-cycle sample
  always_comb begin
    one_valid   = ram0_valid_in ^ ram1_valid_in;
    both_valid  = ram0_valid_in & ram1_valid_in;
    x           = ram0_valid_in ? ram0_data_in : ram1_data_in;
    accept      = !start && one_valid && (state_q == ST_RUN);
    flush_shift = !start && (state_q == ST_FLUSH);
    pad_first   = (border_q == BORDER_REPL) ? x : '0;
    pad_flush   = (border_q == BORDER_REPL) ? w_q[0] : '0;
  end

  // Sticky error flags, cleared only by a new line start
  always_comb begin
    err_d = err_q;
    if (start) begin
      err_d = 2'b00;
    end else begin
      if (both_valid) begin
        err_d[0] = 1'b1;
      end
      if (one_valid && (state_q != ST_RUN)) begin
        err_d[1] = 1'b1;
      end
    end
  end

  // FSM next state, accepted-sample counter and flush counter
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fl_d     = fl_q;
    mode_d   = mode_q;
    border_d = border_q;
    if (start) begin
      state_d  = ST_RUN;
      cnt_d    = '0;
      fl_d     = '0;
      mode_d   = mode;
      border_d = border;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (accept) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(LINE_LEN - 1)) begin
              state_d = ST_FLUSH;
              fl_d    = '0;
            end
          end
        end
        ST_FLUSH: begin
          fl_d = fl_q + 2'd1;
          if (fl_q == flush_count(mode_q) - 2'd1) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Window shift with border padding; tags mark windows that yield an output
  always_comb begin
    w_d        = w_q;
    win_vld_d  = 1'b0;
    win_last_d = 1'b0;
    if (start) begin
      w_d = '{default: '0};
    end else if (accept) begin
      if (cnt_q == '0) begin
        w_d[0] = x;
        w_d[1] = pad_first;
        w_d[2] = pad_first;
        w_d[3] = pad_first;
        w_d[4] = pad_first;
      end else begin
        w_d[0] = x;
        w_d[1] = w_q[0];
        w_d[2] = w_q[1];
        w_d[3] = w_q[2];
        w_d[4] = w_q[3];
      end
      // Output i needs sample i+2 (5-tap) or i+1 (3-tap) in the window
      win_vld_d = (mode_q == MODE_3TAP) ? (cnt_q >= CW'(1)) : (cnt_q >= CW'(2));
    end else if (flush_shift) begin
      w_d[0]     = pad_flush;
      w_d[1]     = w_q[0];
      w_d[2]     = w_q[1];
      w_d[3]     = w_q[2];
      w_d[4]     = w_q[3];
      win_vld_d  = 1'b1;
      win_last_d = (fl_q == flush_count(mode_q) - 2'd1);
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      fl_q       <= '0;
      mode_q     <= MODE_5TAP;
      border_q   <= BORDER_ZERO;
      err_q      <= 2'b00;
      w_q        <= '{default: '0};
      win_vld_q  <= 1'b0;
      win_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fl_q       <= fl_d;
      mode_q     <= mode_d;
      border_q   <= border_d;
      err_q      <= err_d;
      w_q        <= w_d;
      win_vld_q  <= win_vld_d;
      win_last_q <= win_last_d;
    end
  end

  gs_filter_pipe #(
    .DW(DW)
  ) u_pipe (
    .clk   (clk),
    .rst   (rst),
    .clr_i (start),
    .mode_i(mode_q),
    .w0_i  (w_q[0]),
    .w1_i  (w_q[1]),
    .w2_i  (w_q[2]),
    .w3_i  (w_q[3]),
    .w4_i  (w_q[4]),
    .vld_i (win_vld_q),
    .last_i(win_last_q),
    .vld_o (op_valid_out),
    .last_o(line_done),
    .data_o(op_data_out)
  );

  assign err_flags = err_q;

endmodule

// File: doc/gs_filter_line.md
Name: gs_filter_line

Overview:
Parametrised 1-D Gaussian line filter with per-line border handling and ping-pong RAM input.
- Modes: 5-tap [1,4,6,4,1]/16 or 3-tap [1,2,1]/4, with rounding.
- Emits exactly one centred output per input sample of a LINE_LEN line. Trailing outputs are produced by an internal flush after the last sample.
- Sits between the ping-pong line RAMs and the downstream 2-D stage or writeback.

Parameters:
DW, 8, pixel data width (4..16)
LINE_LEN, 256, samples per line (>=5)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin new line: clears state, samples mode/border
mode  in  1  0 = 5-tap, 1 = 3-tap; sampled on start
border  in  1  0 = zero pad, 1 = replicate edge; sampled on start
ram0_valid_in  in  1  RAM0 sample valid
ram0_data_in  in  DW  RAM0 sample
ram1_valid_in  in  1  RAM1 sample valid
ram1_data_in  in  DW  RAM1 sample
op_valid_out  out  1  output sample valid
op_data_out  out  DW  filtered sample
line_done  out  1  one-cycle pulse coincident with the last output of a line
err_flags  out  2  sticky: [0] valid collision, [1] sample outside RUN

Behaviour:
- One clock (clk). Reset is synchronous, active-high (rst).
- Reset state: all outputs 0, FSM IDLE, window/pipeline/counters 0.
- Reset mid-line: line abandoned, no further outputs until the next start.
- Accept condition: exactly one of ram0_valid_in/ram1_valid_in high and FSM in RUN. Data comes from the valid port.
- Both valids high: sample dropped, err_flags[0] set.
- Valid while in IDLE/FLUSH: sample dropped, err_flags[1] set.
- err_flags clear only on rst or start.
- FSM: IDLE -start-> RUN; RUN -(accepted count == LINE_LEN)-> FLUSH; FLUSH -(F synthetic shifts done)-> IDLE. F = 2 (5-tap) or 1 (3-tap).
- start in any state: synchronous clear of window, pipeline, count and errors; enter RUN. start has priority over a same-cycle sample, which is dropped without a flag.
- Window: 5 registers w0 (newest)..w4, shifted only on accept or flush shift.
- First sample x0 loads w0 = x0 and w1..w4 = pad. Pad = x0 (replicate) or 0 (zero).
- Flush shifts insert pad = last sample (replicate) or 0. Flush shifts occur on F consecutive cycles.
- Output generation, 5-tap: after acceptance of sample i+2 (i >= 0), and after each flush shift, output i is computed. Centre = w2, sum = w0 + 4w1 + 6w2 + 4w3 + w4.
- Output generation, 3-tap: from sample i+1 onward. Centre = w1, sum = w0 + 2w1 + w2.
- Arithmetic: sum width DW+4, unsigned.
  - 5-tap: out = (sum + 8) >> 4.
  - 3-tap: out = (sum + 2) >> 2.
  - No saturation is needed; maximum input gives out = 2^DW - 1.
- Latency: op_valid_out rises in cycle t+4 for a window update in cycle t (window, 2 adder stages, round register). The pipeline runs every cycle with a valid tag; input gaps produce output gaps.
- Exactly LINE_LEN outputs per line.
- line_done is high in the same cycle as the LINE_LEN-th op_valid_out.
- op_data_out holds its last value when op_valid_out is low.

Decomposition:
- Package gs_filter_pkg:
  - FSM state enum (IDLE/RUN/FLUSH)
  - MODE_5TAP/MODE_3TAP and BORDER_ZERO/BORDER_REPL constants
  - tap weights
  - round constants (8, 2) and shifts (4, 2)
  - flush counts (2, 1)
- One sub-module, gs_filter_pipe:
  - window-to-output arithmetic (2 adder stages + round) with valid-tag pipeline
  - parametrised by DW
- Top level contains the input mux, error logic, FSM, counter and window/pad insertion.

Test Plan:
- LINE_LEN=8, 5-tap, zero pad, impulse x3=255 (others 0) -> outputs 0,16,64,96,64,16,0,0; line_done with the 8th output.
- 5-tap, zero pad, constant 160 -> outputs 110,150,160,160,160,160,150,110.
- 5-tap, replicate, constant 100 -> eight outputs of 100. All-255 line -> eight outputs of 255.
- 3-tap, zero pad, impulse x3=200 -> outputs 0,0,50,100,50,0,0,0; exactly one flush cycle.
- Both valids high with data 0x11/0x22 mid-line -> sample dropped, count unchanged, err_flags[0]=1 until next start. Valid in IDLE -> err_flags[1]=1.
- rst pulse after 4 accepted samples -> next cycle all outputs 0, FSM IDLE, no outputs. A following start plus 8 samples -> normal 8-output line with first output 4 cycles after the window update for x2.
